// File: rtl/ins_mem_pkg.sv
// Shared types and widths for the instruction main memory.
package ins_mem_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ins_mem_block_store.sv
// Block store: 32-bit word write port, 128-bit combinational block read port.
module ins_mem_block_store
    import ins_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS = 256,
    parameter int unsigned IDX_W        = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [IDX_W-1:0]     widx,
    input  logic [1:0]           wslot,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [IDX_W-1:0]     ridx,
    output logic [BLOCK_W-1:0]   rdata_c
);

    logic [BLOCK_W-1:0] mem_q [DEPTH_BLOCKS];

    // Word write into the selected slot of a block; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[widx][{wslot, 5'd0} +: WORD_W] <= wdata;
        end
    end

    assign rdata_c = mem_q[ridx];

endmodule

// File: rtl/ins_main_memory.sv
// Instruction-cache refill responder: fixed-latency 128-bit block reads.
module ins_main_memory
    import ins_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned DEPTH_BLOCKS = 256,
    parameter int unsigned IDX_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    address,
    output logic [BLOCK_W-1:0]   readdata,
    output logic                 busywait,
    input  logic                 init_we,
    input  logic [IDX_W+1:0]     init_addr,
    input  logic [WORD_W-1:0]    init_word
);

    localparam int unsigned CNT_W    = $clog2(READ_LATENCY) + 1;
    localparam int unsigned CNT_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic                load_c;
    logic                wr_en_c;
    logic [IDX_W-1:0]    rd_idx_c;
    logic [BLOCK_W-1:0]  store_rdata_c;
    logic [BLOCK_W-1:0]  resp_block_c;
    logic                unused_addr_hi_c;

    // Upper address bits alias away; only the block index is used.
    assign unused_addr_hi_c = ^address[ADDR_W-1:IDX_W];

    // Preload is only accepted while idle.
    assign wr_en_c  = init_we && (state_q == IDLE);
    // A single-cycle read loads readdata straight from the live address.
    assign rd_idx_c = (state_q == IDLE) ? address[IDX_W-1:0] : addr_q;

    ins_mem_block_store #(
        .DEPTH_BLOCKS (DEPTH_BLOCKS),
        .IDX_W        (IDX_W)
    ) u_store (
        .clock   (clock),
        .we      (wr_en_c),
        .widx    (init_addr[IDX_W+1:2]),
        .wslot   (init_addr[1:0]),
        .wdata   (init_word),
        .ridx    (rd_idx_c),
        .rdata_c (store_rdata_c)
    );

    // Forward a same-edge preload word so a coincident read sees the new data.
    always_comb begin
        resp_block_c = store_rdata_c;
        if (wr_en_c && (init_addr[IDX_W+1:2] == rd_idx_c)) begin
            resp_block_c[{init_addr[1:0], 5'd0} +: WORD_W] = init_word;
        end
    end

    // Wait is asserted for an accepted-but-unserved request, never in reset.
    assign busywait = reset && (((state_q == IDLE) && read) || (state_q == BUSY));

    // Next-state, latency counter and response load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        load_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read) begin
                    addr_d = address[IDX_W-1:0];
                    if (READ_LATENCY == 1) begin
                        state_d = RESP;
                        load_c  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            BUSY: begin
                if (!read) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    load_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched address and response data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            readdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (load_c) begin
                readdata <= resp_block_c;
            end
        end
    end

endmodule

// File: tb/tb_ins_main_memory.sv
// Scoreboard bench for ins_main_memory (latency 4 main instance, latency 1 side instance).
module tb_ins_main_memory;

    localparam int unsigned LAT = 4;

    logic         clock;
    logic         reset;
    logic         read;
    logic [27:0]  address;
    logic [127:0] readdata;
    logic         busywait;
    logic         init_we;
    logic [9:0]   init_addr;
    logic [31:0]  init_word;

    logic         read1;
    logic [27:0]  address1;
    logic [127:0] rdata1;
    logic         busy1;
    logic         init_we1;
    logic [9:0]   init_addr1;
    logic [31:0]  init_word1;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem_m [1024];
    logic [31:0]  m1 [4];
    logic [127:0] exp_q [$];
    logic [127:0] last_exp = '0;
    int           busy_cnt = 0;

    ins_main_memory #(.READ_LATENCY(LAT), .DEPTH_BLOCKS(256), .IDX_W(8)) u_dut (
        .clock(clock), .reset(reset), .read(read), .address(address),
        .readdata(readdata), .busywait(busywait), .init_we(init_we),
        .init_addr(init_addr), .init_word(init_word)
    );

    ins_main_memory #(.READ_LATENCY(1), .DEPTH_BLOCKS(256), .IDX_W(8)) u_dut_l1 (
        .clock(clock), .reset(reset), .read(read1), .address(address1),
        .readdata(rdata1), .busywait(busy1), .init_we(init_we1),
        .init_addr(init_addr1), .init_word(init_word1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [27:0] a);
        int b;
        b = int'(a[7:0]) * 4;
        return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
    endfunction

    // Monitor: a response is read high with busywait low; the wait before it must be LAT cycles.
    always @(negedge clock) begin
        if (!reset) begin
            busy_cnt = 0;
        end else if (read) begin
            if (busywait) begin
                busy_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", readdata, 'x);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("resp_data", readdata, last_exp);
                    chk("resp_latency", 128'(busy_cnt), 128'(LAT));
                end
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic init_wr(input logic [9:0] wa, input logic [31:0] wd);
        init_we   = 1'b1;
        init_addr = wa;
        init_word = wd;
        mem_m[wa] = wd;
        @(posedge clock); #1;
        init_we = 1'b0;
    endtask

    // Issue a read (optionally with a coincident preload) and hold until served.
    task automatic issue_read(input logic [27:0] a, input bit hold, input bit wr,
                              input logic [9:0] wa, input logic [31:0] wd);
        bit done;
        done    = 1'b0;
        read    = 1'b1;
        address = a;
        if (wr) begin
            init_we   = 1'b1;
            init_addr = wa;
            init_word = wd;
            mem_m[wa] = wd;
        end
        exp_q.push_back(model_block(a));
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 1) init_we = 1'b0;
            if (!busywait) begin
                done = 1'b1;
                break;
            end
        end
        init_we = 1'b0;
        if (!done) chk("read_timeout", 128'(busywait), 128'(0));
        @(posedge clock); #1;
        if (!hold) read = 1'b0;
    endtask

    // Start a read and withdraw it in BUSY cycle k.
    task automatic abort_read(input logic [27:0] a, input int k);
        read    = 1'b1;
        address = a;
        repeat (k) @(posedge clock);
        #1 read = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort_busywait", 128'(busywait), 128'(0));
        chk("abort_readdata", readdata, last_exp);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [27:0] a;
        logic [9:0]  wa;
        logic [31:0] wd;
        bit          hold;
        int          op;

        reset = 1'b0; read = 1'b1; address = 28'h5;
        init_we = 1'b0; init_addr = '0; init_word = '0;
        read1 = 1'b1; address1 = 28'h3; init_we1 = 1'b0; init_addr1 = '0; init_word1 = '0;
        #3;
        chk("reset_busywait", 128'(busywait), 128'(0));
        chk("reset_readdata", readdata, 128'h0);
        chk("reset_busy_l1", 128'(busy1), 128'(0));
        chk("reset_readdata_l1", rdata1, 128'h0);
        read = 1'b0; read1 = 1'b0;
        #10 reset = 1'b1;
        @(posedge clock); #1;

        // Preload image, with known contents in blocks 5 and 6.
        for (int i = 0; i < 1024; i++) init_wr(10'(i), $urandom);
        init_wr({8'd5, 2'd0}, 32'h11111111);
        init_wr({8'd5, 2'd1}, 32'h22222222);
        init_wr({8'd5, 2'd2}, 32'h33333333);
        init_wr({8'd5, 2'd3}, 32'h44444444);
        chk("model_block5", model_block(28'h5), 128'h44444444_33333333_22222222_11111111);

        issue_read(28'h5, 1'b0, 1'b0, '0, '0);
        issue_read(28'h5, 1'b1, 1'b0, '0, '0);
        issue_read(28'h6, 1'b0, 1'b0, '0, '0);

        // Address change mid-BUSY must not affect the response.
        read = 1'b1; address = 28'h5;
        exp_q.push_back(model_block(28'h5));
        @(posedge clock); #1;
        @(posedge clock); #1 address = 28'h9;
        for (int i = 0; i < 20 && busywait; i++) @(negedge clock);
        @(posedge clock); #1 read = 1'b0;

        issue_read(28'h105, 1'b0, 1'b0, '0, '0);
        abort_read(28'h6, 2);
        issue_read(28'h6, 1'b0, 1'b0, '0, '0);

        // Reset in BUSY, with a dropped preload beforehand.
        read = 1'b1; address = 28'h5;
        @(posedge clock); #1;
        init_we = 1'b1; init_addr = {8'd7, 2'd1}; init_word = 32'hDEADBEEF;
        @(posedge clock); #1 init_we = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midreset_busywait", 128'(busywait), 128'(0));
        chk("midreset_readdata", readdata, 128'h0);
        last_exp = '0;
        read = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        issue_read(28'h5, 1'b0, 1'b0, '0, '0);
        issue_read(28'h7, 1'b0, 1'b0, '0, '0);

        // Randomized traffic.
        hold = 1'b0;
        for (int n = 0; n < 60; n++) begin
            op = hold ? $urandom_range(0, 1) : $urandom_range(0, 3);
            a  = 28'($urandom);
            wa = {a[7:0], 2'($urandom)};
            wd = $urandom;
            case (op)
                0, 1: begin
                    hold = 1'($urandom_range(0, 1));
                    issue_read(a, hold, op == 1, wa, wd);
                end
                2: init_wr(10'($urandom), wd);
                default: abort_read(a, $urandom_range(1, LAT - 1));
            endcase
        end
        if (hold) issue_read(28'h5, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        // Latency-1 instance: single wait cycle, coincident preload is visible.
        @(posedge clock); #1;
        for (int w = 0; w < 4; w++) begin
            init_we1 = 1'b1; init_addr1 = {8'd3, 2'(w)}; init_word1 = 32'hA0000000 + 32'(w);
            m1[w] = init_word1;
            @(posedge clock); #1;
        end
        init_we1 = 1'b0;
        read1 = 1'b1; address1 = 28'h103;
        init_we1 = 1'b1; init_addr1 = {8'd3, 2'd2}; init_word1 = 32'hCAFEF00D;
        m1[2] = 32'hCAFEF00D;
        @(negedge clock);
        chk("l1_busy_cycle0", 128'(busy1), 128'(1));
        @(posedge clock); #1 init_we1 = 1'b0;
        @(negedge clock);
        chk("l1_resp_busy", 128'(busy1), 128'(0));
        chk("l1_resp_data", rdata1, {m1[3], m1[2], m1[1], m1[0]});
        @(posedge clock); #1 read1 = 1'b0;
        @(negedge clock);
        chk("l1_idle_busy", 128'(busy1), 128'(0));
        chk("l1_hold_data", rdata1, {m1[3], m1[2], m1[1], m1[0]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
